// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: pipelined integer ALU functional unit between int_rs and the CDB arbiter.
// S0 holds the issued uop and the ALU evaluates it combinationally; S1..S[PIPE_DEPTH]
// are result registers forming an elastic, bubble-collapsing chain towards the CDB.
// Optional feature macro: FU_ALU_PERF_EN adds saturating perf_retired / perf_stall counters.
// DATA_W must match fu_alu_pkg::FU_DATA_W, which sizes the shared uop/bypass structs.

package fu_alu_pkg;

    localparam int FU_DATA_W = 32;
    localparam int ROB_ID_W  = 6;
    localparam int PHY_W     = 7;
    localparam int ARCH_W    = 5;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_ZERO = 2'd1
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2 = 2'd0,
        OP2_IMM = 2'd1
    } op2_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } fu_opcode_e;

    typedef struct packed {
        op1_sel_e               op1_sel;
        op2_sel_e               op2_sel;
        fu_opcode_e             fu_opcode;
        logic [FU_DATA_W-1:0]   rs1_value;
        logic [FU_DATA_W-1:0]   rs2_value;
        logic [FU_DATA_W-1:0]   imm;
        logic [PHY_W-1:0]       rd_phy;
        logic [ARCH_W-1:0]      rd_arch;
        logic [ROB_ID_W-1:0]    rob_id;
    } fu_alu_reg_t;

    typedef struct packed {
        logic                   valid;
        logic [PHY_W-1:0]       rd_phy;
        logic [FU_DATA_W-1:0]   rd_value;
    } bypass_network_t;

endpackage

module fu_alu_pipe
    import fu_alu_pkg::*;
#(
    parameter int DATA_W     = fu_alu_pkg::FU_DATA_W,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    int_rs_valid,
    output logic                    fu_alu_ready,
    input  fu_alu_reg_t             fu_alu_reg_in,
    output bypass_network_t         bypass,
    output logic                    cdb_valid,
    input  logic                    cdb_ready,
    output logic [ROB_ID_W-1:0]     cdb_rob_id,
    output logic [PHY_W-1:0]        cdb_rd_phy,
    output logic [ARCH_W-1:0]       cdb_rd_arch,
    output logic [DATA_W-1:0]       cdb_rd_value,
    output logic [DATA_W-1:0]       cdb_rs1_value_dbg,
    output logic [DATA_W-1:0]       cdb_rs2_value_dbg
`ifdef FU_ALU_PERF_EN
    ,
    output logic [31:0]             perf_retired,
    output logic [31:0]             perf_stall
`endif
);

    localparam int SHAMT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef struct packed {
        logic [ROB_ID_W-1:0]    rob_id;
        logic [PHY_W-1:0]       rd_phy;
        logic [ARCH_W-1:0]      rd_arch;
        logic [DATA_W-1:0]      rd_value;
        logic [DATA_W-1:0]      rs1_value;
        logic [DATA_W-1:0]      rs2_value;
    } res_t;

    fu_alu_reg_t            r_s0;
    logic [PIPE_DEPTH:0]    r_valid;
    res_t                   r_res [1:PIPE_DEPTH];

    logic [PIPE_DEPTH:0]    w_adv;
    logic                   w_allValid;
    logic [DATA_W-1:0]      w_opA;
    logic [DATA_W-1:0]      w_opB;
    logic [SHAMT_W-1:0]     w_shamt;
    logic [DATA_W-1:0]      w_result;
    res_t                   w_s0Res;
    logic                   w_issue;

    // A stage may advance unless it and every stage downstream are full while the CDB stalls
    always_comb begin
        w_allValid = 1'b1;
        w_adv      = '0;
        for (int i = PIPE_DEPTH; i >= 0; i--) begin
            w_allValid = w_allValid & r_valid[i];
            w_adv[i]   = ~w_allValid | cdb_ready;
        end
    end

    assign fu_alu_ready = w_adv[0];
    assign w_issue      = int_rs_valid & w_adv[0] & ~flush;

    // Operand selection; unsupported select encodings yield zero
    always_comb begin
        w_opA = '0;
        w_opB = '0;
        case (r_s0.op1_sel)
            OP1_RS1:  w_opA = r_s0.rs1_value[DATA_W-1:0];
            OP1_ZERO: w_opA = '0;
            default:  w_opA = '0;
        endcase
        case (r_s0.op2_sel)
            OP2_RS2: w_opB = r_s0.rs2_value[DATA_W-1:0];
            OP2_IMM: w_opB = r_s0.imm[DATA_W-1:0];
            default: w_opB = '0;
        endcase
    end

    assign w_shamt = w_opB[SHAMT_W-1:0];

    // Execute-stage ALU evaluated on the uop held in S0; unknown opcodes give zero
    always_comb begin
        w_result = '0;
        case (r_s0.fu_opcode)
            ALU_ADD:  w_result = w_opA + w_opB;
            ALU_SUB:  w_result = w_opA - w_opB;
            ALU_XOR:  w_result = w_opA ^ w_opB;
            ALU_OR:   w_result = w_opA | w_opB;
            ALU_AND:  w_result = w_opA & w_opB;
            ALU_SLL:  w_result = w_opA << w_shamt;
            ALU_SRL:  w_result = w_opA >> w_shamt;
            ALU_SRA:  w_result = $signed(w_opA) >>> w_shamt;
            ALU_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(w_opA) < $signed(w_opB))};
            ALU_SLTU: w_result = {{(DATA_W-1){1'b0}}, (w_opA < w_opB)};
            default:  w_result = '0;
        endcase
    end

    // Package the S0 result with its tags and raw operands for the first result register
    always_comb begin
        w_s0Res           = '0;
        w_s0Res.rob_id    = r_s0.rob_id;
        w_s0Res.rd_phy    = r_s0.rd_phy;
        w_s0Res.rd_arch   = r_s0.rd_arch;
        w_s0Res.rd_value  = w_result;
        w_s0Res.rs1_value = r_s0.rs1_value[DATA_W-1:0];
        w_s0Res.rs2_value = r_s0.rs2_value[DATA_W-1:0];
    end

    // Valid chain: bubble-collapsing advance, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= int_rs_valid;
            end
            for (int i = 1; i <= PIPE_DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end
    end

    // Issue register S0 captures a uop only when it is actually accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= '0;
        end else if (w_issue) begin
            r_s0 <= fu_alu_reg_in;
        end
    end

    // Result registers move only real uops forward so a stalled CDB payload stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= PIPE_DEPTH; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            if (w_adv[1] && r_valid[0]) begin
                r_res[1] <= w_s0Res;
            end
            for (int i = 2; i <= PIPE_DEPTH; i++) begin
                if (w_adv[i] && r_valid[i-1]) begin
                    r_res[i] <= r_res[i-1];
                end
            end
        end
    end

    // Bypass announces the S0 result exactly once, in the cycle S0 hands off to S1
    always_comb begin
        bypass          = '0;
        bypass.valid    = r_valid[0] & w_adv[1] & ~flush;
        bypass.rd_phy   = r_s0.rd_phy;
        bypass.rd_value = w_result;
    end

    assign cdb_valid         = r_valid[PIPE_DEPTH];
    assign cdb_rob_id        = r_res[PIPE_DEPTH].rob_id;
    assign cdb_rd_phy        = r_res[PIPE_DEPTH].rd_phy;
    assign cdb_rd_arch       = r_res[PIPE_DEPTH].rd_arch;
    assign cdb_rd_value      = r_res[PIPE_DEPTH].rd_value;
    assign cdb_rs1_value_dbg = r_res[PIPE_DEPTH].rs1_value;
    assign cdb_rs2_value_dbg = r_res[PIPE_DEPTH].rs2_value;

`ifdef FU_ALU_PERF_EN
    logic [31:0] r_perfRetired;
    logic [31:0] r_perfStall;

    // Saturating retire/stall counters; only reset clears them, flush leaves them alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perfRetired <= '0;
            r_perfStall   <= '0;
        end else begin
            if (cdb_valid && cdb_ready && (r_perfRetired != 32'hFFFF_FFFF)) begin
                r_perfRetired <= r_perfRetired + 32'd1;
            end
            if (cdb_valid && !cdb_ready && (r_perfStall != 32'hFFFF_FFFF)) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end

    assign perf_retired = r_perfRetired;
    assign perf_stall   = r_perfStall;
`endif

endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb_fu_alu_pipe: directed bench for fu_alu_pipe at PIPE_DEPTH=2, DATA_W=32.
// Inputs change 1 time unit after the rising edge; outputs are sampled in that window.
// When FU_ALU_PERF_EN is defined the performance counters are exercised as well.

module tb_fu_alu_pipe;
    import fu_alu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   int_rs_valid;
    logic                   fu_alu_ready;
    fu_alu_reg_t            fu_alu_reg_in;
    bypass_network_t        bypass;
    logic                   cdb_valid;
    logic                   cdb_ready;
    logic [ROB_ID_W-1:0]    cdb_rob_id;
    logic [PHY_W-1:0]       cdb_rd_phy;
    logic [ARCH_W-1:0]      cdb_rd_arch;
    logic [31:0]            cdb_rd_value;
    logic [31:0]            cdb_rs1_value_dbg;
    logic [31:0]            cdb_rs2_value_dbg;
`ifdef FU_ALU_PERF_EN
    logic [31:0]            perf_retired;
    logic [31:0]            perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    fu_alu_pipe #(
        .DATA_W     (32),
        .PIPE_DEPTH (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .int_rs_valid      (int_rs_valid),
        .fu_alu_ready      (fu_alu_ready),
        .fu_alu_reg_in     (fu_alu_reg_in),
        .bypass            (bypass),
        .cdb_valid         (cdb_valid),
        .cdb_ready         (cdb_ready),
        .cdb_rob_id        (cdb_rob_id),
        .cdb_rd_phy        (cdb_rd_phy),
        .cdb_rd_arch       (cdb_rd_arch),
        .cdb_rd_value      (cdb_rd_value),
        .cdb_rs1_value_dbg (cdb_rs1_value_dbg),
        .cdb_rs2_value_dbg (cdb_rs2_value_dbg)
`ifdef FU_ALU_PERF_EN
        ,
        .perf_retired      (perf_retired),
        .perf_stall        (perf_stall)
`endif
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the stimulus gets stuck
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic fu_alu_reg_t makeUop(input fu_opcode_e op, input op1_sel_e s1,
                                            input op2_sel_e s2, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [31:0] imm,
                                            input logic [6:0] phy, input logic [5:0] rob);
        fu_alu_reg_t u;
        u           = '0;
        u.fu_opcode = op;
        u.op1_sel   = s1;
        u.op2_sel   = s2;
        u.rs1_value = rs1;
        u.rs2_value = rs2;
        u.imm       = imm;
        u.rd_phy    = phy;
        u.rd_arch   = phy[4:0];
        u.rob_id    = rob;
        return u;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input fu_alu_reg_t uop);
        int_rs_valid  = valid;
        fu_alu_reg_in = uop;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Issue one uop into an idle pipe and check both the bypass and the CDB result
    task automatic runOp(input string tag, input fu_alu_reg_t uop, input logic [31:0] expected);
        applyStimulus(1'b1, uop);
        step();
        applyStimulus(1'b0, uop);
        checkOutput({tag, "_byp"}, bypass.rd_value, expected);
        step();
        step();
        checkOutput({tag, "_cdbv"}, 32'(cdb_valid), 32'd1);
        checkOutput({tag, "_cdb"}, cdb_rd_value, expected);
    endtask

    initial begin
        fu_alu_reg_t u1, u2, u3, u4;

        rst          = 1'b1;
        flush        = 1'b0;
        cdb_ready    = 1'b1;
        applyStimulus(1'b0, '0);
        step();
        step();
        checkOutput("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        checkOutput("rst_byp_valid", 32'(bypass.valid), 32'd0);
        checkOutput("rst_ready", 32'(fu_alu_ready), 32'd1);
        checkOutput("rst_cdb_value", cdb_rd_value, 32'd0);
        rst = 1'b0;

        // Back-to-back ADD then SUB
        u1 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd5, 32'd7, 32'd0, 7'd10, 6'd1);
        u2 = makeUop(ALU_SUB, OP1_RS1, OP2_RS2, 32'd3, 32'd5, 32'd0, 7'd11, 6'd2);
        applyStimulus(1'b1, u1);
        settle();
        checkOutput("a_ready", 32'(fu_alu_ready), 32'd1);
        step();
        applyStimulus(1'b1, u2);
        settle();
        checkOutput("a_byp1_valid", 32'(bypass.valid), 32'd1);
        checkOutput("a_byp1_phy", 32'(bypass.rd_phy), 32'd10);
        checkOutput("a_byp1_value", bypass.rd_value, 32'd12);
        step();
        applyStimulus(1'b0, u2);
        settle();
        checkOutput("a_byp2_valid", 32'(bypass.valid), 32'd1);
        checkOutput("a_byp2_value", bypass.rd_value, 32'hFFFF_FFFE);
        checkOutput("a_cdb_early", 32'(cdb_valid), 32'd0);
        step();
        checkOutput("a_cdb1_valid", 32'(cdb_valid), 32'd1);
        checkOutput("a_cdb1_value", cdb_rd_value, 32'd12);
        checkOutput("a_cdb1_rob", 32'(cdb_rob_id), 32'd1);
        checkOutput("a_cdb1_phy", 32'(cdb_rd_phy), 32'd10);
        checkOutput("a_cdb1_arch", 32'(cdb_rd_arch), 32'd10);
        checkOutput("a_cdb1_rs1", cdb_rs1_value_dbg, 32'd5);
        checkOutput("a_cdb1_rs2", cdb_rs2_value_dbg, 32'd7);
        checkOutput("a_byp3_valid", 32'(bypass.valid), 32'd0);
        step();
        checkOutput("a_cdb2_valid", 32'(cdb_valid), 32'd1);
        checkOutput("a_cdb2_value", cdb_rd_value, 32'hFFFF_FFFE);
        checkOutput("a_cdb2_rob", 32'(cdb_rob_id), 32'd2);
        step();
        checkOutput("a_cdb_drained", 32'(cdb_valid), 32'd0);

        // Opcode and operand-select vectors
        runOp("sra", makeUop(ALU_SRA, OP1_RS1, OP2_RS2, 32'h8000_0000, 32'd4, 32'd0, 7'd1, 6'd1), 32'hF800_0000);
        runOp("slt_neg", makeUop(ALU_SLT, OP1_RS1, OP2_RS2, 32'hFFFF_FFFF, 32'd1, 32'd0, 7'd1, 6'd1), 32'd1);
        runOp("slt_pos", makeUop(ALU_SLT, OP1_RS1, OP2_RS2, 32'd1, 32'hFFFF_FFFF, 32'd0, 7'd1, 6'd1), 32'd0);
        runOp("sltu_big", makeUop(ALU_SLTU, OP1_RS1, OP2_RS2, 32'hFFFF_FFFF, 32'd1, 32'd0, 7'd1, 6'd1), 32'd0);
        runOp("sltu_small", makeUop(ALU_SLTU, OP1_RS1, OP2_RS2, 32'd1, 32'hFFFF_FFFF, 32'd0, 7'd1, 6'd1), 32'd1);
        runOp("zero_imm", makeUop(ALU_ADD, OP1_ZERO, OP2_IMM, 32'hDEAD, 32'd9, 32'h123, 7'd1, 6'd1), 32'h123);
        runOp("sll_mask", makeUop(ALU_SLL, OP1_RS1, OP2_RS2, 32'd1, 32'h3F, 32'd0, 7'd1, 6'd1), 32'h8000_0000);
        runOp("srl", makeUop(ALU_SRL, OP1_RS1, OP2_RS2, 32'h8000_0000, 32'd4, 32'd0, 7'd1, 6'd1), 32'h0800_0000);
        runOp("xor", makeUop(ALU_XOR, OP1_RS1, OP2_RS2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 7'd1, 6'd1), 32'h0FF0_0FF0);
        runOp("or", makeUop(ALU_OR, OP1_RS1, OP2_RS2, 32'h0F00, 32'h00F0, 32'd0, 7'd1, 6'd1), 32'h0FF0);
        runOp("and", makeUop(ALU_AND, OP1_RS1, OP2_RS2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 7'd1, 6'd1), 32'h0F00_0F00);
        runOp("add_wrap", makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'hFFFF_FFFF, 32'd2, 32'd0, 7'd1, 6'd1), 32'd1);
        runOp("bad_opc", makeUop(fu_opcode_e'(4'd15), OP1_RS1, OP2_RS2, 32'd5, 32'd7, 32'd0, 7'd1, 6'd1), 32'd0);
        runOp("bad_op2", makeUop(ALU_ADD, OP1_RS1, op2_sel_e'(2'd3), 32'd5, 32'd7, 32'd9, 7'd1, 6'd1), 32'd5);
        runOp("bad_op1", makeUop(ALU_ADD, op1_sel_e'(2'd2), OP2_RS2, 32'd5, 32'd7, 32'd0, 7'd1, 6'd1), 32'd7);
        step();
        checkOutput("ops_drained", 32'(cdb_valid), 32'd0);

        // Backpressure: CDB stalled for five cycles while four issues are offered
        u1 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd1, 32'd1, 32'd0, 7'd3, 6'd3);
        u2 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd2, 32'd2, 32'd0, 7'd4, 6'd4);
        u3 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd3, 32'd3, 32'd0, 7'd5, 6'd5);
        u4 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd4, 32'd4, 32'd0, 7'd6, 6'd6);
        cdb_ready = 1'b0;
        applyStimulus(1'b1, u1);
        settle();
        checkOutput("st_ready1", 32'(fu_alu_ready), 32'd1);
        step();
        applyStimulus(1'b1, u2);
        settle();
        checkOutput("st_ready2", 32'(fu_alu_ready), 32'd1);
        step();
        applyStimulus(1'b1, u3);
        settle();
        checkOutput("st_ready3", 32'(fu_alu_ready), 32'd1);
        step();
        applyStimulus(1'b1, u4);
        settle();
        checkOutput("st_full_ready", 32'(fu_alu_ready), 32'd0);
        checkOutput("st_full_cdbv", 32'(cdb_valid), 32'd1);
        checkOutput("st_full_value", cdb_rd_value, 32'd2);
        checkOutput("st_full_byp", 32'(bypass.valid), 32'd0);
        step();
        checkOutput("st_hold_ready", 32'(fu_alu_ready), 32'd0);
        checkOutput("st_hold_value", cdb_rd_value, 32'd2);
        checkOutput("st_hold_rob", 32'(cdb_rob_id), 32'd3);
        step();
        cdb_ready = 1'b1;
        settle();
        checkOutput("st_rel_ready", 32'(fu_alu_ready), 32'd1);
        checkOutput("st_rel_value", cdb_rd_value, 32'd2);
        step();
        applyStimulus(1'b0, u4);
        checkOutput("st_d2_value", cdb_rd_value, 32'd4);
        checkOutput("st_d2_rob", 32'(cdb_rob_id), 32'd4);
        step();
        checkOutput("st_d3_value", cdb_rd_value, 32'd6);
        checkOutput("st_d3_rob", 32'(cdb_rob_id), 32'd5);
        step();
        checkOutput("st_d4_valid", 32'(cdb_valid), 32'd1);
        checkOutput("st_d4_value", cdb_rd_value, 32'd8);
        checkOutput("st_d4_rob", 32'(cdb_rob_id), 32'd6);
        step();
        checkOutput("st_drained", 32'(cdb_valid), 32'd0);

        // Flush with two uops in flight and a new issue offered in the flush cycle
        u1 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd10, 32'd1, 32'd0, 7'd20, 6'd20);
        u2 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd20, 32'd1, 32'd0, 7'd21, 6'd21);
        u3 = makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd30, 32'd1, 32'd0, 7'd22, 6'd22);
        applyStimulus(1'b1, u1);
        step();
        applyStimulus(1'b1, u2);
        step();
        applyStimulus(1'b1, u3);
        flush = 1'b1;
        settle();
        checkOutput("fl_byp_forced", 32'(bypass.valid), 32'd0);
        step();
        flush = 1'b0;
        applyStimulus(1'b0, u3);
        settle();
        checkOutput("fl_cdbv1", 32'(cdb_valid), 32'd0);
        checkOutput("fl_ready", 32'(fu_alu_ready), 32'd1);
        step();
        checkOutput("fl_cdbv2", 32'(cdb_valid), 32'd0);
        step();
        checkOutput("fl_cdbv3", 32'(cdb_valid), 32'd0);

        // Reset while a result is stalled on the CDB
        cdb_ready = 1'b0;
        applyStimulus(1'b1, makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'h11, 32'h22, 32'd0, 7'd7, 6'd7));
        step();
        applyStimulus(1'b0, '0);
        step();
        step();
        checkOutput("rm_pre_valid", 32'(cdb_valid), 32'd1);
        checkOutput("rm_pre_value", cdb_rd_value, 32'h33);
        rst = 1'b1;
        step();
        checkOutput("rm_valid", 32'(cdb_valid), 32'd0);
        checkOutput("rm_value", cdb_rd_value, 32'd0);
        checkOutput("rm_rob", 32'(cdb_rob_id), 32'd0);
        rst = 1'b0;

`ifdef FU_ALU_PERF_EN
        // Counters: cleared by reset, three transfers, four stall cycles, flush keeps them
        checkOutput("pf_rst_ret", perf_retired, 32'd0);
        checkOutput("pf_rst_stall", perf_stall, 32'd0);
        applyStimulus(1'b1, makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd1, 32'd0, 32'd0, 7'd1, 6'd1));
        step();
        applyStimulus(1'b1, makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd2, 32'd0, 32'd0, 7'd2, 6'd2));
        step();
        applyStimulus(1'b1, makeUop(ALU_ADD, OP1_RS1, OP2_RS2, 32'd3, 32'd0, 32'd0, 7'd3, 6'd3));
        step();
        applyStimulus(1'b0, '0);
        step();
        step();
        step();
        step();
        checkOutput("pf_mid_stall", perf_stall, 32'd4);
        checkOutput("pf_mid_ret", perf_retired, 32'd0);
        cdb_ready = 1'b1;
        step();
        step();
        step();
        checkOutput("pf_ret", perf_retired, 32'd3);
        checkOutput("pf_stall", perf_stall, 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("pf_fl_ret", perf_retired, 32'd3);
        checkOutput("pf_fl_stall", perf_stall, 32'd4);
`endif

        cdb_ready = 1'b1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
- Parametrised successor of the integer-RS ALU functional unit.
- Sits between int_rs and the CDB arbiter.
- Adds a configurable result-pipeline depth, real CDB valid/ready backpressure with an elastic stall chain, and a pipeline flush.
- Drives the bypass network from the execute stage.

Parameters:
- DATA_W, 32: operand/result width; shift amount uses the low $clog2(DATA_W) bits of b.
- PIPE_DEPTH, 1: result registers between the execute stage S0 and the CDB; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all in-flight uops (mispredict recovery)
- int_rs_valid  in  1  issue request from int_rs
- fu_alu_ready  out  1  FU accepts an issue this cycle
- fu_alu_reg_in  in  fu_alu_reg_t  issued uop: op1_sel, op2_sel, fu_opcode, rs1/rs2_value, imm, rd_phy, rd_arch, rob_id
- bypass  out  bypass_network_t  {valid, rd_phy, rd_value} from S0
- cdb_valid  out  1  result valid to CDB
- cdb_ready  in  1  CDB accepts result
- cdb_rob_id, cdb_rd_phy, cdb_rd_arch  out  field widths of fu_alu_reg_t  result tags
- cdb_rd_value  out  DATA_W  result
- cdb_rs1_value_dbg, cdb_rs2_value_dbg  out  DATA_W  operand values for RVFI

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset state: every stage valid = 0, so cdb_valid = 0, bypass.valid = 0, fu_alu_ready = 1. Data registers are don't-care except CDB payload, which resets to 0.
- Stages:
  - S0 is the issue register, which the ALU evaluates combinationally.
  - S1..S[PIPE_DEPTH] are result registers.
  - S[PIPE_DEPTH] drives the cdb_* outputs.
- Elastic advance:
  - last stage: adv = ~v_last | cdb_ready.
  - stage i: adv_i = ~v_i | adv_{i+1}.
  - Stage i captures stage i-1 when adv_i; its valid is set to v_{i-1} & adv_i-path, i.e. a standard bubble-collapsing chain.
- Issue:
  - fu_alu_ready = adv_0, combinational from cdb_ready and the valids.
  - S0 loads fu_alu_reg_in when int_rs_valid & fu_alu_ready.
  - int_rs_valid while not ready is not consumed; int_rs must hold it.
- Latency: a uop accepted at edge k shows cdb_valid from edge k+PIPE_DEPTH with no stalls. Throughput is 1/cycle.
- Operand select:
  - a: OP1_RS1 = rs1_value; OP1_ZERO = 0.
  - b: OP2_RS2 = rs2_value; OP2_IMM = imm.
  - Any other select value gives 0.
- Opcodes:
  - ADD, SUB, XOR, OR, AND: modulo 2^DATA_W.
  - SLL, SRL: logical shifts.
  - SRA: arithmetic shift.
  - SLT: signed compare, zero-extended 1-bit result.
  - SLTU: unsigned compare, zero-extended 1-bit result.
  - Unknown opcode: result 0, not X.
- Bypass: bypass.valid = v0 & adv_1, so it asserts exactly once per uop, in the cycle S0 hands off. rd_phy and rd_value come from S0.
- CDB handshake: the payload is held stable while cdb_valid & ~cdb_ready. A transfer completes on cdb_valid & cdb_ready.
- Flush:
  - Clears all valids at the next edge and overrides any issue that cycle.
  - A CDB transfer coincident with flush still counts as completed.
  - bypass.valid is forced 0 while flush is high.
- rst mid-operation: identical to flush, plus CDB payload cleared.
- PIPE_DEPTH = 1 with cdb_ready tied 1 is cycle-equivalent to the previous ALU FU.

Optional Feature:
- FU_ALU_PERF_EN defined:
  - Adds outputs perf_retired (32) and perf_stall (32).
  - perf_retired increments on each CDB transfer.
  - perf_stall increments each cycle cdb_valid & ~cdb_ready.
  - Both saturate at 2^32-1 and are cleared by rst only; flush does not clear them.
- FU_ALU_PERF_EN undefined: the ports and counters do not exist.

Test Plan:
- PIPE_DEPTH=2, cdb_ready=1; issue ADD 5+7 then SUB 3-5 back-to-back -> cdb_rd_value 12 then 0xFFFFFFFE on consecutive cycles, 2 edges after each issue. bypass.valid fires once each.
- SRA 0x80000000>>>4 -> 0xF8000000. SLT(-1,1) -> 1. SLTU(0xFFFFFFFF,1) -> 0. OP1_ZERO+IMM 0x123 -> 0x123.
- PIPE_DEPTH=2; hold cdb_ready=0 for 5 cycles with 4 issues offered -> at most 3 accepted, fu_alu_ready=0 thereafter, payload stable. Release -> results drain in order, no loss or duplication.
- Two uops in flight; assert flush one cycle with int_rs_valid=1 -> no cdb_valid afterwards, the issued uop is dropped, fu_alu_ready=1 next cycle.
- rst asserted mid-stall with cdb_valid=1 -> cdb_valid=0 and cdb_rd_value=0 after the edge.
- FU_ALU_PERF_EN: 3 transfers plus 4 stall cycles -> perf_retired=3, perf_stall=4. Flush leaves both unchanged.
